fifo_push_arbiter: RTL

Round-robin arbiter that shares the push side of one fifo_flops instance among N_REQ producers. Each producer has a valid/ready handshake. The block owns fifo push/Din through one register stage. An internal occupancy/credit counter guarantees no push is issued to a full FIFO, despite the registered push latency. It sits between producer agents and fifo_flops; the pop side is consumer-driven and only observed.

---
 rtl/fifo_push_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Brief    : Round-robin arbiter that shares the push side of one fifo_flops
//            among N_REQ valid/ready producers. It uses a registered push
//            stage and a credit counter, so no push is ever sent to a full FIFO.
//            Optional macro ARB_BURST_LOCK_EN keeps a grant locked to one
//            requester for up to DEPTH consecutive transfers.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*WIDTH-1:0]       req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [WIDTH-1:0]             fifo_din,
    output logic                         fifo_push,
    input  logic                         fifo_full,
    input  logic                         fifo_pop,
    input  logic                         fifo_pndng,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow_err
);

    localparam int IDW = $clog2(N_REQ);
    localparam int OCW = $clog2(DEPTH+1);
    localparam logic [OCW-1:0] DEPTH_C = OCW'(DEPTH);
    localparam logic [IDW:0]   NREQ_C  = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LAST_C  = IDW'(N_REQ-1);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_idx;
    logic           rr_found;
    logic [IDW:0]   rr_sum;
    logic [IDW-1:0] sel_idx;
    logic           sel_found;
    logic           credit_ok;
    logic           grant;
    logic           pop_ok;
    logic [IDW-1:0] next_ptr;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (rr_sum >= NREQ_C) begin
                rr_sum = rr_sum - NREQ_C;
            end
            if (!rr_found && req_valid[rr_sum[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[IDW-1:0];
            end
        end
    end

`ifdef ARB_BURST_LOCK_EN
    logic           lock_active;
    logic [IDW-1:0] lock_id;
    logic [OCW-1:0] burst_cnt;
    logic           lock_hit;

    assign lock_hit  = lock_active && req_valid[lock_id] && (burst_cnt < DEPTH_C);
    assign sel_found = lock_hit || rr_found;
    assign sel_idx   = lock_hit ? lock_id : rr_idx;

    // Any no-grant cycle (valid drop or credit stall) ends the burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_active <= 1'b0;
            lock_id     <= '0;
            burst_cnt   <= '0;
        end else if (grant) begin
            lock_active <= 1'b1;
            lock_id     <= sel_idx;
            burst_cnt   <= lock_hit ? (burst_cnt + OCW'(1)) : OCW'(1);
        end else begin
            lock_active <= 1'b0;
            burst_cnt   <= '0;
        end
    end
`else
    assign sel_found = rr_found;
    assign sel_idx   = rr_idx;
`endif

    assign credit_ok = (occupancy < DEPTH_C);
    // Gating with rst keeps the grant bus quiet while the block is held in reset.
    assign grant     = rst && credit_ok && sel_found;
    assign pop_ok    = fifo_pop && fifo_pndng && (occupancy != '0);
    assign next_ptr  = (sel_idx == LAST_C) ? '0 : (sel_idx + IDW'(1));

    for (genvar i = 0; i < N_REQ; i++) begin : g_ready
        assign req_ready[i] = grant && (sel_idx == IDW'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_push <= 1'b0;
            fifo_din  <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            fifo_push <= 1'b1;
            fifo_din  <= req_data[int'(sel_idx)*WIDTH +: WIDTH];
            grant_id  <= sel_idx;
            rr_ptr    <= next_ptr;
        end else begin
            fifo_push <= 1'b0;
        end
    end

    // Credits are reserved at grant time, covering the word still in the push register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else begin
            case ({grant, pop_ok})
                2'b10:   occupancy <= occupancy + OCW'(1);
                2'b01:   occupancy <= occupancy - OCW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err <= 1'b0;
        end else if (fifo_push && fifo_full) begin
            overflow_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
